// File: rtl/fetch_queue.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue between a synchronous
// instruction memory and decode; a taken branch redirects fetch and flushes everything.
module fetch_queue #(
   parameter int                     PC_WIDTH = 16,
   parameter int                     IR_WIDTH = 32,
   parameter int                     DEPTH    = 4,
   parameter logic [PC_WIDTH-1:0]    RESET_PC = '0,
   parameter int                     PC_STEP  = 4
) (
   input  logic                I_CLOCK,
   input  logic                I_RESET,
   input  logic                I_LOCK,
   input  logic [PC_WIDTH-1:0] I_BranchPC,
   input  logic                I_BranchAddrSelect,
   input  logic                I_STALL,
   output logic                O_IMEM_EN,
   output logic [PC_WIDTH-1:0] O_IMEM_ADDR,
   input  logic [IR_WIDTH-1:0] I_IMEM_DATA,
   output logic                O_LOCK,
   output logic                O_VALID,
   output logic [PC_WIDTH-1:0] O_PC,
   output logic [IR_WIDTH-1:0] O_IR,
   output logic                O_FetchStall
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0]         DEPTH_C = (CW + 1)'(DEPTH);
   localparam logic [PC_WIDTH-1:0] STEP_C  = PC_WIDTH'(PC_STEP);

   logic [PC_WIDTH-1:0] r_fetch_pc;
   logic [PC_WIDTH-1:0] r_inflight_pc;
   logic                r_inflight;
   logic [PC_WIDTH-1:0] r_q_pc [DEPTH];
   logic [IR_WIDTH-1:0] r_q_ir [DEPTH];
   logic [AW-1:0]       r_rd_ptr;
   logic [AW-1:0]       r_wr_ptr;
   logic [CW-1:0]       r_count;
   logic                r_lock;
   logic [PC_WIDTH-1:0] r_hold_pc;
   logic [IR_WIDTH-1:0] r_hold_ir;

   logic [CW:0] w_occupancy;
   logic        w_valid;
   logic        w_issue;
   logic        w_push;
   logic        w_pop;

   // Credit counts the in-flight word so a response always finds a free slot;
   // only registered state feeds this, so I_STALL never reaches O_IMEM_EN.
   assign w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
   assign w_valid     = (r_count != '0);
   assign w_issue     = I_LOCK & ~I_RESET & ~I_BranchAddrSelect & (w_occupancy < DEPTH_C);
   assign w_push      = r_inflight & ~I_BranchAddrSelect;
   assign w_pop       = w_valid & ~I_STALL & ~I_BranchAddrSelect;

   always_ff @(negedge I_CLOCK) begin
      if (I_RESET) begin
         r_fetch_pc    <= RESET_PC;
         r_inflight_pc <= '0;
         r_inflight    <= 1'b0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
         r_lock        <= 1'b0;
         r_hold_pc     <= '0;
         r_hold_ir     <= '0;
         // NOTE: queue storage is reset so the head outputs are defined (zero) after reset.
         for (int i = 0; i < DEPTH; i++) begin
            r_q_pc[i] <= '0;
            r_q_ir[i] <= '0;
         end
      end else begin
         r_lock <= I_LOCK;
         if (w_valid) begin
            r_hold_pc <= r_q_pc[r_rd_ptr];
            r_hold_ir <= r_q_ir[r_rd_ptr];
         end
         if (I_BranchAddrSelect) begin
            r_fetch_pc <= I_BranchPC;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
         end else begin
            if (w_issue) begin
               r_inflight    <= 1'b1;
               r_inflight_pc <= r_fetch_pc;
               r_fetch_pc    <= r_fetch_pc + STEP_C;
            end else begin
               r_inflight <= 1'b0;
            end
            if (w_push) begin
               r_q_pc[r_wr_ptr] <= r_inflight_pc + STEP_C;
               r_q_ir[r_wr_ptr] <= I_IMEM_DATA;
               r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   assign O_IMEM_EN    = w_issue;
   assign O_IMEM_ADDR  = r_fetch_pc;
   assign O_LOCK       = r_lock;
   assign O_VALID      = w_valid;
   assign O_FetchStall = ~w_valid;
   assign O_PC         = w_valid ? r_q_pc[r_rd_ptr] : r_hold_pc;
   assign O_IR         = w_valid ? r_q_ir[r_rd_ptr] : r_hold_ir;

endmodule
